adder_bist: RTL



---
 rtl/adder_bist.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/adder_bist.sv
// Built-in self test for a one-bit full adder: sweeps {a,b,cin} 000..111, checks s/cout after a settle delay.
// Latency: SETTLE_CYCLES+2 cycles per vector, 8*(SETTLE_CYCLES+2) per run; start is ignored while busy.
// Optional feature: define ADDER_BIST_STOP_ON_FAIL_EN to end the run at the first mismatching vector.
module adder_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             cin,
    input  logic             s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       fail_vec,
    output logic             fail_valid
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("adder_bist: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       fvec_q, fvec_d;
    logic             fvld_q, fvld_d;

    logic exp_s;
    logic exp_c;
    logic mismatch;
    logic stop_now;

    assign exp_s    = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    assign exp_c    = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    assign mismatch = (s != exp_s) || (cout != exp_c);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        fvld_d  = fvld_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d   = 3'd0;
                    err_d   = '0;
                    fvec_d  = 3'd0;
                    fvld_d  = 1'b0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                vec_d   = idx_q;
                cnt_d   = SETTLE_LD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (!(&err_q)) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fvld_q) begin
                        fvec_d = vec_q;
                        fvld_d = 1'b1;
                    end
                end
                // idx never wraps: the run ends on the idx==7 test, or earlier when stopping on fail
                if (stop_now || idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= '0;
            fvec_q  <= 3'd0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fvld_q  <= fvld_d;
        end
    end

    assign a          = vec_q[2];
    assign b          = vec_q[1];
    assign cin        = vec_q[0];
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = done && (err_q == '0);
    assign err_cnt    = err_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvld_q;

endmodule
